// File: rtl/pingpong_buffer_mc_if.sv
// pingpong_buffer_mc_if: sample, read and status bundle for the multi-channel ping-pong buffer
//   master: drives sample frames, read requests and release (ADC front-end / FFT side)
//   slave : the buffer; returns read data, ready pulse, overflow flag and write count
interface pingpong_buffer_mc_if #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 256,
    parameter int CHANNELS = 4
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
    logic [CHANNELS*WIDTH-1:0] sample_i;
    logic                      sample_valid_i;
    logic                      rd_req_i;
    logic [CW-1:0]             rd_ch_i;
    logic [AW-1:0]             rd_addr_i;
    logic [WIDTH-1:0]          rd_data_o;
    logic                      rd_valid_o;
    logic                      release_i;
    logic                      buffer_ready_o;
    logic                      overflow_o;
    logic [AW:0]               wr_count_o;
    modport master (
        output sample_i, sample_valid_i, rd_req_i, rd_ch_i, rd_addr_i, release_i,
        input  rd_data_o, rd_valid_o, buffer_ready_o, overflow_o, wr_count_o
    );
    modport slave (
        input  sample_i, sample_valid_i, rd_req_i, rd_ch_i, rd_addr_i, release_i,
        output rd_data_o, rd_valid_o, buffer_ready_o, overflow_o, wr_count_o
    );
endinterface

// File: rtl/pingpong_buffer_mc.sv
// pingpong_buffer_mc: two-bank multi-channel sample buffer, one bank captures frames while the reader owns the other
//   clk_i : single rising-edge clock
//   rst_i : asynchronous active-high reset
//   bus   : slave side of pingpong_buffer_mc_if (frames in, random-access reads, release, status)
module pingpong_buffer_mc #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 256,
    parameter int CHANNELS = 4
) (
    input logic                 clk_i,
    input logic                 rst_i,
    pingpong_buffer_mc_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
    typedef enum logic {EMPTY, HELD} state_t;
    state_t                    state_q, state_d;
    logic [AW-1:0]             wr_ptr_q, wr_ptr_d;
    logic                      wr_bank_q, wr_bank_d;
    logic                      rd_bank_q, rd_bank_d;
    logic                      ready_q, ready_d;
    logic                      ovf_q, ovf_d;
    logic                      rd_valid_q, rd_valid_d;
    logic [CW-1:0]             rd_ch_q, rd_ch_d;
    logic                      complete;
    logic                      swap;
    logic [CHANNELS*WIDTH-1:0] rd_words;
    always_comb begin
        complete   = bus.sample_valid_i && wr_ptr_q == AW'(DEPTH - 1);
        // a release in the completing cycle frees the reader first, so the new block is taken
        swap       = complete && (state_q == EMPTY || bus.release_i);
        wr_ptr_d   = bus.sample_valid_i ? wr_ptr_q + 1'b1 : wr_ptr_q;
        wr_bank_d  = swap ? ~wr_bank_q : wr_bank_q;
        rd_bank_d  = swap ? wr_bank_q : rd_bank_q;
        state_d    = swap ? HELD : bus.release_i ? EMPTY : state_q;
        ready_d    = swap;
        ovf_d      = ovf_q || (complete && !swap);
        rd_valid_d = bus.rd_req_i && state_q == HELD;
        rd_ch_d    = bus.rd_ch_i;
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= EMPTY;
            wr_ptr_q   <= '0;
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b1;
            ready_q    <= 1'b0;
            ovf_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_ch_q    <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            ready_q    <= ready_d;
            ovf_q      <= ovf_d;
            rd_valid_q <= rd_valid_d;
            rd_ch_q    <= rd_ch_d;
        end
    end
    // one RAM per channel, bank select as address MSB; every channel reads each cycle and the
    // registered channel picks the word, giving one-cycle read latency
    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [WIDTH-1:0] mem [2*DEPTH];
        logic [WIDTH-1:0] word_q;
        always_ff @(posedge clk_i) begin
            if (bus.sample_valid_i) mem[{wr_bank_q, wr_ptr_q}] <= bus.sample_i[c*WIDTH +: WIDTH];
            word_q <= mem[{rd_bank_q, bus.rd_addr_i}];
        end
        assign rd_words[c*WIDTH +: WIDTH] = word_q;
    end
    assign bus.rd_data_o      = rd_valid_q ? rd_words[rd_ch_q*WIDTH +: WIDTH] : '0;
    assign bus.rd_valid_o     = rd_valid_q;
    assign bus.buffer_ready_o = ready_q;
    assign bus.overflow_o     = ovf_q;
    assign bus.wr_count_o     = {1'b0, wr_ptr_q};
endmodule

// File: tb/tb_pingpong_buffer_mc.sv
// tb_pingpong_buffer_mc: directed plus randomized checks of the ping-pong buffer against a block-level model
module tb_pingpong_buffer_mc;
    localparam int W = 16;
    localparam int D = 256;
    localparam int C = 4;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;
    pingpong_buffer_mc_if #(.WIDTH(W), .DEPTH(D), .CHANNELS(C)) bus();
    pingpong_buffer_mc #(.WIDTH(W), .DEPTH(D), .CHANNELS(C)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
    int n_assert = 0;
    int n_fail = 0;
    logic [W-1:0] cur [C][D];
    logic [W-1:0] hb [C][D];
    int wp;
    int ready_cnt;
    bit held, ovf, e_ready, e_valid;
    logic [W-1:0] e_data;
    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic model_reset();
        wp = 0; held = 0; ovf = 0; e_ready = 0; e_valid = 0; e_data = '0;
    endtask
    task automatic check_all(string tag);
        chk({tag, ".rd_valid"}, 32'(bus.rd_valid_o), 32'(e_valid));
        chk({tag, ".rd_data"}, 32'(bus.rd_data_o), 32'(e_data));
        chk({tag, ".ready"}, 32'(bus.buffer_ready_o), 32'(e_ready));
        chk({tag, ".overflow"}, 32'(bus.overflow_o), 32'(ovf));
        chk({tag, ".wr_count"}, 32'(bus.wr_count_o), 32'(wp));
    endtask
    task automatic idle();
        bus.sample_i = '0; bus.sample_valid_i = 0; bus.rd_req_i = 0;
        bus.rd_ch_i = '0; bus.rd_addr_i = '0; bus.release_i = 0;
    endtask
    // model: a block of DEPTH frames is handed over when the reader is free (or releasing now),
    // otherwise it is lost and overflow sticks; reads see only the handed-over block
    task automatic tick(string tag);
        bit done;
        @(posedge clk);
        e_valid = bus.rd_req_i && held;
        e_data = e_valid ? hb[bus.rd_ch_i][bus.rd_addr_i] : '0;
        e_ready = 0;
        done = 0;
        if (bus.sample_valid_i) begin
            for (int c = 0; c < C; c++) cur[c][wp] = bus.sample_i[c*W +: W];
            done = (wp == D - 1);
            wp = (wp + 1) % D;
        end
        if (bus.release_i) held = 0;
        if (done) begin
            if (!held) begin
                hb = cur; held = 1; e_ready = 1; ready_cnt++;
            end else ovf = 1;
        end
        #1 check_all(tag);
        @(negedge clk);
    endtask
    task automatic set_frame(int k, bit rnd);
        logic [1:0] cc;
        logic [13:0] kk;
        for (int c = 0; c < C; c++) begin
            cc = 2'(c);
            kk = 14'(k);
            bus.sample_i[c*W +: W] = rnd ? W'($urandom) : {cc, kk};
        end
    endtask
    task automatic fill(string tag, int n, bit rnd, int rel_at);
        for (int k = 0; k < n; k++) begin
            set_frame(k, rnd);
            bus.sample_valid_i = 1;
            bus.release_i = (k == rel_at);
            tick(tag);
        end
        bus.sample_valid_i = 0;
        bus.release_i = 0;
    endtask
    task automatic rand_reads(string tag, int n);
        for (int i = 0; i < n; i++) begin
            bus.rd_req_i = 1;
            bus.rd_ch_i = 2'($urandom_range(C - 1));
            bus.rd_addr_i = 8'($urandom_range(D - 1));
            tick(tag);
        end
        bus.rd_req_i = 0;
    endtask
    initial begin
        int since;
        rst = 1;
        idle();
        model_reset();
        ready_cnt = 0;
        repeat (2) @(negedge clk);
        check_all("reset");
        rst = 0;
        tick("post_reset");
        // read while EMPTY is dropped
        bus.rd_req_i = 1; bus.rd_ch_i = 2'd2; bus.rd_addr_i = 8'd17;
        tick("t3_empty");
        chk("t3_empty_valid", 32'(bus.rd_valid_o), 32'd0);
        bus.rd_req_i = 0;
        // T2 fill with the structured pattern
        fill("t2_fill", D, 0, -1);
        chk("t2_ready_cnt", 32'(ready_cnt), 32'd1);
        tick("t2_after");
        // T3 readback
        bus.rd_req_i = 1; bus.rd_ch_i = 2'd2; bus.rd_addr_i = 8'd17;
        tick("t3_read");
        chk("t3_data_8011", 32'(bus.rd_data_o), 32'h8011);
        bus.rd_req_i = 0;
        rand_reads("t3_rand", 8);
        // T4 second block with no release overflows, held block intact
        fill("t4_fill", D, 1, -1);
        chk("t4_overflow", 32'(bus.overflow_o), 32'd1);
        chk("t4_ready_cnt", 32'(ready_cnt), 32'd1);
        bus.rd_req_i = 1; bus.rd_ch_i = 2'd1; bus.rd_addr_i = 8'd5;
        tick("t4_read");
        chk("t4_data_4005", 32'(bus.rd_data_o), 32'h4005);
        bus.rd_req_i = 0;
        rand_reads("t4_rand", 8);
        // T1 asynchronous reset mid-block while a read response is showing
        fill("t1_partial", 100, 1, -1);
        bus.rd_req_i = 1;
        tick("t1_read");
        bus.rd_req_i = 0;
        #2 rst = 1;
        #1;
        chk("t1_rd_valid", 32'(bus.rd_valid_o), 32'd0);
        chk("t1_rd_data", 32'(bus.rd_data_o), 32'd0);
        chk("t1_ready", 32'(bus.buffer_ready_o), 32'd0);
        chk("t1_overflow", 32'(bus.overflow_o), 32'd0);
        chk("t1_wr_count", 32'(bus.wr_count_o), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 0;
        tick("t1_post");
        // T5 release coinciding with completion of block 2
        ready_cnt = 0;
        fill("t5_blk1", D, 0, -1);
        fill("t5_blk2", D, 1, D - 1);
        chk("t5_ready_cnt", 32'(ready_cnt), 32'd2);
        chk("t5_overflow", 32'(bus.overflow_o), 32'd0);
        rand_reads("t5_rand", 12);
        // T6 streaming four blocks, release ~100 cycles after each ready
        bus.release_i = 1;
        tick("t6_release");
        bus.release_i = 0;
        ready_cnt = 0;
        since = -1;
        for (int k = 0; k < 4 * D; k++) begin
            set_frame(k, 1);
            bus.sample_valid_i = 1;
            bus.release_i = (since == 100);
            bus.rd_req_i = $urandom_range(1);
            bus.rd_ch_i = 2'($urandom_range(C - 1));
            bus.rd_addr_i = 8'($urandom_range(D - 1));
            tick("t6_stream");
            if (bus.release_i) since = -1;
            if (e_ready) since = 0;
            else if (since >= 0) since++;
        end
        idle();
        rand_reads("t6_tail", 16);
        chk("t6_ready_cnt", 32'(ready_cnt), 32'd4);
        chk("t6_overflow", 32'(bus.overflow_o), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
